// File: rtl/cpu6_hazard_unit_pkg.sv
// cpu6_hazard_unit_pkg
// Shared definitions for the cpu6 hazard unit: forward-select encodings,
// control FSM states, instruction field positions and a field-extract helper.
// No ports (package).
package cpu6_hazard_unit_pkg;

  // EX operand source selects
  localparam logic [1:0] CPU6_FWD_RF  = 2'b00;
  localparam logic [1:0] CPU6_FWD_WB  = 2'b01;
  localparam logic [1:0] CPU6_FWD_MEM = 2'b10;

  // Register field positions inside an instruction word
  localparam int CPU6_RS1_LSB = 15;
  localparam int CPU6_RS2_LSB = 20;
  localparam int CPU6_RD_LSB  = 7;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_REDIR   = 2'b01,
    ST_MEMWAIT = 2'b10
  } hz_state_t;

  // Per-cycle pipeline control bundle
  typedef struct packed {
    logic stallF;
    logic stallD;
    logic stallE;
    logic stallM;
    logic flushD;
    logic flushE;
    logic flushW;
  } hz_ctl_t;

  // Pull a 5-bit register index out of an instruction word
  function automatic logic [4:0] regField(input logic [31:0] instr, input int lsb);
    return instr[lsb +: 5];
  endfunction

endpackage

// File: rtl/cpu6_hazard_unit_if.sv
// cpu6_hazard_unit_if
// Bundles the pipeline-side signals of the cpu6 hazard unit.
// Ports (signals):
//   ID:   rs1D, rs2D, usesrs1D, usesrs2D
//   EX:   instrE, regwriteE, memtoregE, branchtakenE, jumpE
//   MEM:  rdM, regwriteM, memtoregM, memwriteM, dmem_ready
//   WB:   rdW, regwriteW
//   out:  stallF/D/E/M, flushD/E/W, forwardAE/BE, mem_timeout, stall_cnt, flush_cnt
// Modports: master = pipeline datapath, slave = hazard unit.
interface cpu6_hazard_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [4:0]      rs1D;
  logic [4:0]      rs2D;
  logic            usesrs1D;
  logic            usesrs2D;
  logic [XLEN-1:0] instrE;
  logic            regwriteE;
  logic            memtoregE;
  logic            branchtakenE;
  logic            jumpE;
  logic [4:0]      rdM;
  logic            regwriteM;
  logic            memtoregM;
  logic            memwriteM;
  logic            dmem_ready;
  logic [4:0]      rdW;
  logic            regwriteW;
  logic            stallF;
  logic            stallD;
  logic            stallE;
  logic            stallM;
  logic            flushD;
  logic            flushE;
  logic            flushW;
  logic [1:0]      forwardAE;
  logic [1:0]      forwardBE;
  logic            mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs1D, rs2D, usesrs1D, usesrs2D, instrE, regwriteE, memtoregE,
           branchtakenE, jumpE, rdM, regwriteM, memtoregM, memwriteM,
           dmem_ready, rdW, regwriteW,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
           forwardAE, forwardBE, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1D, rs2D, usesrs1D, usesrs2D, instrE, regwriteE, memtoregE,
           branchtakenE, jumpE, rdM, regwriteM, memtoregM, memwriteM,
           dmem_ready, rdW, regwriteW,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
           forwardAE, forwardBE, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/cpu6_fwd_sel.sv
// cpu6_fwd_sel
// Chooses where one EX operand comes from: regfile, WB result or MEM result.
// Ports:
//   rsE        in  5  EX source register
//   rdM        in  5  MEM destination, regwriteM/memtoregM its control bits
//   rdW        in  5  WB destination, regwriteW its write enable
//   fwd        out 2  select (CPU6_FWD_RF / CPU6_FWD_WB / CPU6_FWD_MEM)
module cpu6_fwd_sel
  import cpu6_hazard_unit_pkg::*;
(
  input  logic [4:0] rsE,
  input  logic [4:0] rdM,
  input  logic       regwriteM,
  input  logic       memtoregM,
  input  logic [4:0] rdW,
  input  logic       regwriteW,
  output logic [1:0] fwd
);

  // MEM wins over WB because it holds the younger value. A load in MEM has
  // no data yet, so it never forwards; x0 is hardwired and never forwards.
  always_comb begin
    fwd = CPU6_FWD_RF;
    if (regwriteM && !memtoregM && (rdM != 5'd0) && (rdM == rsE)) begin
      fwd = CPU6_FWD_MEM;
    end else if (regwriteW && (rdW != 5'd0) && (rdW == rsE)) begin
      fwd = CPU6_FWD_WB;
    end
  end

endmodule

// File: rtl/cpu6_hazard_unit.sv
// cpu6_hazard_unit
// Pipeline control for the cpu6 5-stage core: stalls, flushes, EX operand
// forwarding, a redirect shadow / data-memory wait FSM, and saturating
// performance counters. flushE feeds the flash input of the ID/EX register.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset
//   hz     slave modport of cpu6_hazard_unit_if (all pipeline signals)
// Parameters: XLEN (>=32), IMEM_LAT (0..3), MEM_TIMEOUT (>=1), CNT_W.
module cpu6_hazard_unit
  import cpu6_hazard_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int IMEM_LAT    = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  cpu6_hazard_unit_if.slave hz
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX    = WAIT_W'(MEM_TIMEOUT);
  localparam logic [1:0]        SHADOW_INIT = 2'(IMEM_LAT);

  hz_state_t         state;
  logic [1:0]        shadowCnt;
  logic [WAIT_W-1:0] waitCnt;
  logic              memTimeout;
  logic [CNT_W-1:0]  stallCnt;
  logic [CNT_W-1:0]  flushCnt;

  logic [4:0] rs1E;
  logic [4:0] rs2E;
  logic [4:0] rdE;
  logic       memReq;
  logic       redirect;
  logic       ldUse;
  logic       memStall;
  hz_ctl_t    ctl;
  logic [1:0] fwdA;
  logic [1:0] fwdB;
  logic       unusedInstr;

  assign rs1E = regField(hz.instrE[31:0], CPU6_RS1_LSB);
  assign rs2E = regField(hz.instrE[31:0], CPU6_RS2_LSB);
  assign rdE  = regField(hz.instrE[31:0], CPU6_RD_LSB);
  assign unusedInstr = ^{hz.instrE[XLEN-1:25], hz.instrE[14:12], hz.instrE[6:0]};

  assign memReq   = hz.memtoregM | hz.memwriteM;
  assign redirect = hz.branchtakenE | hz.jumpE;
  assign memStall = memReq & ~hz.dmem_ready;
  assign ldUse    = hz.memtoregE & hz.regwriteE & (rdE != 5'd0) &
                    ((hz.usesrs1D & (hz.rs1D == rdE)) | (hz.usesrs2D & (hz.rs2D == rdE)));

  // Priority decode of this cycle's control. A memory stall freezes the whole
  // front of the pipe, so any redirect or load-use seen at the same time is
  // simply held and re-decoded once memory answers. While in the redirect
  // shadow the ID instruction is wrong-path, so load-use is not considered.
  always_comb begin
    ctl = '0;
    if (reset) begin
      ctl.flushD = 1'b1;
      ctl.flushE = 1'b1;
    end else if (memStall) begin
      ctl.stallF = 1'b1;
      ctl.stallD = 1'b1;
      ctl.stallE = 1'b1;
      ctl.stallM = 1'b1;
      ctl.flushW = 1'b1;
    end else if (redirect) begin
      ctl.flushD = 1'b1;
      ctl.flushE = 1'b1;
    end else if (state == ST_REDIR) begin
      ctl.flushD = 1'b1;
    end else if (ldUse) begin
      ctl.stallF = 1'b1;
      ctl.stallD = 1'b1;
      ctl.flushE = 1'b1;
    end
  end

  // FSM, wait/shadow counters, sticky timeout flag and performance counters.
  // MEMWAIT falls back to the normal decode as soon as memory is ready, so a
  // held redirect takes effect in the release cycle. The shadow counter is
  // reloaded by every redirect, including one that lands inside the shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      shadowCnt  <= '0;
      waitCnt    <= '0;
      memTimeout <= 1'b0;
      stallCnt   <= '0;
      flushCnt   <= '0;
    end else begin
      if (ctl.stallF && (stallCnt != '1)) begin
        stallCnt <= stallCnt + CNT_W'(1);
      end
      if (memStall) begin
        state <= ST_MEMWAIT;
        if (waitCnt != WAIT_MAX) begin
          waitCnt <= waitCnt + WAIT_W'(1);
        end
        if (waitCnt >= (WAIT_MAX - WAIT_W'(1))) begin
          memTimeout <= 1'b1;
        end
      end else begin
        waitCnt <= '0;
        if (redirect) begin
          if (flushCnt != '1) begin
            flushCnt <= flushCnt + CNT_W'(1);
          end
          if (IMEM_LAT > 0) begin
            state     <= ST_REDIR;
            shadowCnt <= SHADOW_INIT;
          end else begin
            state <= ST_RUN;
          end
        end else if (state == ST_REDIR) begin
          if (shadowCnt > 2'd1) begin
            shadowCnt <= shadowCnt - 2'd1;
          end else begin
            shadowCnt <= '0;
            state     <= ST_RUN;
          end
        end else begin
          state <= ST_RUN;
        end
      end
    end
  end

  cpu6_fwd_sel u_fwd_a (
    .rsE       (rs1E),
    .rdM       (hz.rdM),
    .regwriteM (hz.regwriteM),
    .memtoregM (hz.memtoregM),
    .rdW       (hz.rdW),
    .regwriteW (hz.regwriteW),
    .fwd       (fwdA)
  );

  cpu6_fwd_sel u_fwd_b (
    .rsE       (rs2E),
    .rdM       (hz.rdM),
    .regwriteM (hz.regwriteM),
    .memtoregM (hz.memtoregM),
    .rdW       (hz.rdW),
    .regwriteW (hz.regwriteW),
    .fwd       (fwdB)
  );

  assign hz.stallF      = ctl.stallF;
  assign hz.stallD      = ctl.stallD;
  assign hz.stallE      = ctl.stallE;
  assign hz.stallM      = ctl.stallM;
  assign hz.flushD      = ctl.flushD;
  assign hz.flushE      = ctl.flushE;
  assign hz.flushW      = ctl.flushW;
  assign hz.forwardAE   = reset ? CPU6_FWD_RF : fwdA;
  assign hz.forwardBE   = reset ? CPU6_FWD_RF : fwdB;
  assign hz.mem_timeout = memTimeout;
  assign hz.stall_cnt   = stallCnt;
  assign hz.flush_cnt   = flushCnt;

endmodule
